nf10_wrr_input_arbiter: RTL and testbench

Weighted round-robin packet arbiter that merges NUM_QUEUES AXI-Stream inputs onto one AXI-Stream output at packet granularity. Each queue may send up to its programmed weight in consecutive packets before the grant moves on. It sits between the RX queues and the output port lookup stage, in the same position as the plain round-robin input arbiter, and is used where ports need unequal bandwidth shares. It has no internal buffering: data passes straight through from the granted input to the output.

---
 rtl/nf10_wrr_input_arbiter_if.sv | 18 +
 rtl/nf10_wrr_input_arbiter.sv | 150 +++++++++++++++
 tb/tb_nf10_wrr_input_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_wrr_input_arbiter_if.sv
// AXI-Stream bundle shared by both sides of nf10_wrr_input_arbiter.
// LANES > 1 gives a flattened multi-queue bus (lane i occupies slice i);
// LANES = 1 gives a plain single stream.
interface nf10_wrr_input_arbiter_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int LANES       = 1
);
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tstrb;
  logic [LANES*TUSER_WIDTH-1:0]  tuser;
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tready;
  logic [LANES-1:0]              tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_wrr_input_arbiter.sv
// Weighted round-robin packet arbiter: merges NUM_QUEUES AXI-Stream inputs
// onto one output at packet granularity. A queue may send up to its weight
// (0 treated as 1) in consecutive packets before the grant moves on.
// Pure pass-through, no buffering.
// Optional: define WRR_PKT_COUNTERS_EN to add per-queue packet counters
// (pkt_count, 32 bits per queue).
module nf10_wrr_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int WEIGHT_WIDTH         = 4
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_resetn,
  nf10_wrr_input_arbiter_if.slave              s_axis,
  nf10_wrr_input_arbiter_if.master             m_axis,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0]   weights,
  output logic [$clog2(NUM_QUEUES)-1:0]        cur_queue
`ifdef WRR_PKT_COUNTERS_EN
  ,
  output logic [NUM_QUEUES*32-1:0]             pkt_count
`endif
);

  localparam int QW = $clog2(NUM_QUEUES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state;
  logic [WEIGHT_WIDTH-1:0]          credit;

  logic [C_M_AXIS_DATA_WIDTH-1:0]   sel_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] sel_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  sel_user;
  logic                             sel_valid;
  logic                             sel_last;
  logic                             xfer_last;

  logic                             found_hi, found_lo, found;
  logic [QW-1:0]                    q_hi, q_lo, next_q;
  logic [WEIGHT_WIDTH-1:0]          w_hi, w_lo, next_w;

  // Select the slice of the currently granted queue.
  always_comb begin : sel_mux
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      if (cur_queue == QW'(q)) begin
        sel_data  = s_axis.tdata[q*C_S_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
        sel_strb  = s_axis.tstrb[q*(C_S_AXIS_DATA_WIDTH/8) +: C_M_AXIS_DATA_WIDTH/8];
        sel_user  = s_axis.tuser[q*C_S_AXIS_TUSER_WIDTH +: C_M_AXIS_TUSER_WIDTH];
        sel_valid = s_axis.tvalid[q];
        sel_last  = s_axis.tlast[q];
      end
    end
  end

  // Wrapping scan from cur_queue+1, ending at cur_queue itself.
  // Split into "above cur_queue" and "at or below" passes; the first valid
  // queue above wins, otherwise the lowest valid one at or below.
  always_comb begin : grant_search
    found_hi = 1'b0;
    found_lo = 1'b0;
    q_hi     = '0;
    q_lo     = '0;
    w_hi     = '0;
    w_lo     = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      if (s_axis.tvalid[q]) begin
        if (QW'(q) > cur_queue) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            q_hi     = QW'(q);
            w_hi     = weights[q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          q_lo     = QW'(q);
          w_lo     = weights[q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end
    end
    found  = found_hi | found_lo;
    next_q = found_hi ? q_hi : q_lo;
    next_w = found_hi ? w_hi : w_lo;
    if (next_w == '0) next_w = WEIGHT_WIDTH'(1);
  end

  // Drive the output stream and the per-queue readies.
  always_comb begin : output_drive
    m_axis.tdata  = sel_data;
    m_axis.tstrb  = sel_strb;
    m_axis.tuser  = sel_user;
    m_axis.tlast  = sel_last;
    m_axis.tvalid = (state == SEND) && sel_valid;
    s_axis.tready = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      if (state == SEND && cur_queue == QW'(q)) s_axis.tready[q] = m_axis.tready[0];
    end
  end

  assign xfer_last = (state == SEND) && sel_valid && m_axis.tready[0] && sel_last;

  // Grant FSM: IDLE picks a queue, SEND passes one packet through.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= IDLE;
      cur_queue <= '0;
      credit    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid && credit != '0) begin
            state <= SEND;
          end else if (found) begin
            cur_queue <= next_q;
            credit    <= next_w;
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer_last) begin
            credit <= (credit != '0) ? credit - WEIGHT_WIDTH'(1) : '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WRR_PKT_COUNTERS_EN
  // Count completed packets per queue; wraps at 2^32.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_count <= '0;
    end else if (xfer_last) begin
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        if (cur_queue == QW'(q)) pkt_count[q*32 +: 32] <= pkt_count[q*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nf10_wrr_input_arbiter.sv
// Scoreboard bench for nf10_wrr_input_arbiter. Packet beats carry a
// (queue, sequence, beat) word so every output beat identifies its source.
module tb_nf10_wrr_input_arbiter;
  localparam int NQ = 5;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int WW = 4;
  localparam int QW = 3;

  logic              axi_aclk = 1'b0;
  logic              axi_resetn;
  logic [NQ*WW-1:0]  weights;
  logic [QW-1:0]     cur_queue;
`ifdef WRR_PKT_COUNTERS_EN
  logic [NQ*32-1:0]  pkt_count;
`endif

  always #5 axi_aclk = ~axi_aclk;

  nf10_wrr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(NQ)) s_bus ();
  nf10_wrr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(1))  m_bus ();

  nf10_wrr_input_arbiter #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .NUM_QUEUES          (NQ),
    .WEIGHT_WIDTH        (WW)
  ) dut (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .s_axis    (s_bus),
    .m_axis    (m_bus),
    .weights   (weights),
    .cur_queue (cur_queue)
`ifdef WRR_PKT_COUNTERS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  typedef struct { logic [31:0] word; logic last; } beat_t;
  typedef struct { int unsigned q; logic [31:0] word; logic last; } exp_t;

  beat_t src [NQ][$];
  exp_t  exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  int bp_cycles  = 0;
  int stall_after = -1;
  int stall_len   = 0;
  bit gap_pending = 1'b0;
  bit lat_pending = 1'b0;
  bit force_valid = 1'b0;
  bit fire [NQ];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(int unsigned q, int unsigned seq, int unsigned b);
    return {8'(q), 16'(seq), 8'(b)};
  endfunction

  function automatic bit srcs_empty();
    for (int i = 0; i < NQ; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_pkt(input int unsigned q, input int unsigned seq, input int unsigned nb);
    beat_t b;
    for (int unsigned i = 0; i < nb; i++) begin
      b.word = mk_word(q, seq, i);
      b.last = (i == nb - 1);
      src[q].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int unsigned q, input int unsigned seq, input int unsigned nb);
    exp_t e;
    for (int unsigned i = 0; i < nb; i++) begin
      e.q    = q;
      e.word = mk_word(q, seq, i);
      e.last = (i == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NQ; i++) src[i].delete();
    exp_q.delete();
    gap_pending = 1'b0;
    lat_pending = 1'b0;
  endtask

  task automatic do_reset();
    axi_resetn = 1'b0;
    flush_all();
    beats_seen = 0;
    bp_cycles  = 0;
    stall_len  = 0;
    stall_after = -1;
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
  endtask

  task automatic wait_grant(input int unsigned q, input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge axi_aclk);
      #1;
      if (m_bus.tvalid[0] && cur_queue == QW'(q)) break;
    end
    check(tag, {m_bus.tvalid[0], cur_queue}, {1'b1, QW'(q)});
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 500; n++) begin
      @(negedge axi_aclk);
      if (exp_q.size() == 0 && srcs_empty()) break;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(negedge axi_aclk);
  endtask

  // Source driver and output monitor: sample at negedge, update after posedge.
  initial begin
    exp_t  e;
    logic [31:0] w;
    logic        l;
    forever begin
      @(negedge axi_aclk);
      for (int i = 0; i < NQ; i++) fire[i] = s_bus.tvalid[i] && s_bus.tready[i];
      if (axi_resetn === 1'b1) begin
        if (lat_pending) begin
          check("grant_lat", m_bus.tvalid, 1);
          lat_pending = 1'b0;
        end
        if (gap_pending) begin
          check("gap_idle", m_bus.tvalid, 0);
          gap_pending = 1'b0;
          lat_pending = !srcs_empty();
        end
        if (m_bus.tvalid[0] && !m_bus.tready[0]) begin
          bp_cycles++;
          check("bp_ready", s_bus.tready, 0);
          if (exp_q.size() > 0) check("bp_hold", m_bus.tdata, {8{exp_q[0].word}});
        end
        if (m_bus.tvalid[0] && m_bus.tready[0]) begin
          check("s_ready_onehot", s_bus.tready, NQ'(1) << cur_queue);
          if (exp_q.size() == 0) begin
            check("beat_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("queue", cur_queue, e.q);
            check("tdata", m_bus.tdata, {8{e.word}});
            check("tuser", m_bus.tuser, {4{e.word}});
            check("tstrb", m_bus.tstrb, e.word);
            check("tlast", m_bus.tlast, e.last);
            if (e.last) gap_pending = 1'b1;
          end
          beats_seen++;
        end
      end
      @(posedge axi_aclk);
      #1;
      for (int i = 0; i < NQ; i++)
        if (fire[i] && axi_resetn && src[i].size() > 0) void'(src[i].pop_front());
      for (int i = 0; i < NQ; i++) begin
        if (src[i].size() > 0 || force_valid) begin
          w = (src[i].size() > 0) ? src[i][0].word : 32'hffff_0000;
          l = (src[i].size() > 0) ? src[i][0].last : 1'b1;
          s_bus.tvalid[i] = 1'b1;
        end else begin
          w = '0;
          l = 1'b0;
          s_bus.tvalid[i] = 1'b0;
        end
        s_bus.tdata[i*DW +: DW]     = {8{w}};
        s_bus.tuser[i*UW +: UW]     = {4{w}};
        s_bus.tstrb[i*DW/8 +: DW/8] = w;
        s_bus.tlast[i]              = l;
      end
      if (stall_len > 0 && beats_seen == stall_after) begin
        m_bus.tready[0] = 1'b0;
        stall_len--;
      end else begin
        m_bus.tready[0] = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_resetn = 1'b0;
    weights    = {NQ{4'd1}};

    // Reset held with every input valid.
    force_valid = 1'b1;
    repeat (4) @(posedge axi_aclk);
    #2;
    check("rst_m_tvalid", m_bus.tvalid, 0);
    check("rst_s_tready", s_bus.tready, 0);
    check("rst_cur_queue", cur_queue, 0);
    force_valid = 1'b0;

    // Equal weights: q0 first, q2 joins once q0 holds the grant.
    do_reset();
    weights = {NQ{4'd1}};
    for (int unsigned s = 0; s < 3; s++) begin
      load_pkt(0, s, 1);
      expect_pkt(0, s, 1);
      expect_pkt(2, s, 1);
    end
    wait_grant(0, "eq_first_grant");
    for (int unsigned s = 0; s < 3; s++) load_pkt(2, s, 1);
    drain("eq_drain");

    // Weighted share: q0 weight 3, q1 weight 1, 2-beat packets.
    do_reset();
    weights = {NQ{4'd1}};
    weights[3:0] = 4'd3;
    for (int unsigned s = 0; s < 6; s++) load_pkt(0, s, 2);
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned s = 0; s < 3; s++) expect_pkt(0, r*3 + s, 2);
      expect_pkt(1, r, 2);
    end
    wait_grant(0, "wt_first_grant");
    for (int unsigned s = 0; s < 2; s++) load_pkt(1, s, 2);
    drain("wt_drain");

    // Credit discard: q0 leaves credit behind, q1 must not inherit it.
    do_reset();
    weights = {NQ{4'd1}};
    weights[3:0] = 4'd3;
    load_pkt(0, 0, 1);
    expect_pkt(0, 0, 1);
    expect_pkt(1, 0, 2);
    expect_pkt(0, 1, 1);
    expect_pkt(1, 1, 2);
    wait_grant(0, "disc_grant0");
    load_pkt(1, 0, 2);
    load_pkt(1, 1, 2);
    wait_grant(1, "disc_grant1");
    load_pkt(0, 1, 1);
    drain("disc_drain");

    // Backpressure: 5 stalled cycles on beat 2 of a 4-beat packet.
    do_reset();
    weights = {NQ{4'd1}};
    load_pkt(0, 0, 4);
    expect_pkt(0, 0, 4);
    stall_after = 1;
    stall_len   = 5;
    drain("bp_drain");
    check("bp_cycles", bp_cycles, 5);
    check("bp_beats", beats_seen, 4);

    // Reset asserted mid-packet from q3.
    do_reset();
    weights = {NQ{4'd1}};
    load_pkt(3, 0, 4);
    expect_pkt(3, 0, 4);
    for (int n = 0; n < 200; n++) begin
      @(posedge axi_aclk);
      #3;
      if (beats_seen >= 2) break;
    end
    check("rstmid_progress", beats_seen, 2);
    check("rstmid_pre_queue", cur_queue, 3);
    axi_resetn = 1'b0;
    #1;
    check("rstmid_m_tvalid", m_bus.tvalid, 0);
    check("rstmid_s_tready", s_bus.tready, 0);
    check("rstmid_cur_queue", cur_queue, 0);
    flush_all();
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_resetn = 1'b1;

`ifdef WRR_PKT_COUNTERS_EN
    // Packet counters: 7 packets from q3.
    do_reset();
    weights = {NQ{4'd1}};
    for (int unsigned s = 0; s < 7; s++) begin
      load_pkt(3, s, 1);
      expect_pkt(3, s, 1);
    end
    drain("cnt_drain");
    for (int i = 0; i < NQ; i++)
      check($sformatf("pkt_count_%0d", i), pkt_count[i*32 +: 32], (i == 3) ? 7 : 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
